seqcheck: RTL and testbench

- Serial sequence detector: Moore FSM that watches a 1-bit input stream, sampled once per clock, for the pattern 1-0-1-1-0 (first bit received first).
- `out` pulses high for one cycle per detection.
- Current state is exported on `statout` for debug and observation.
- Standalone lab-level block; `in` comes from a synchronous source in the `clk` domain.

---
 rtl/seqcheck_if.sv | 9 +
 rtl/seqcheck.sv | 53 +++++
 tb/tb_seqcheck.sv | 129 ++++++++++++
 3 files changed

// File: rtl/seqcheck_if.sv
// Serial-bit stream bundle for the seqcheck detector: data bit in, detection flag and state out.
interface seqcheck_if;
    logic       in;
    logic       out;
    logic [2:0] statout;

    modport master (output in, input out, input statout);
    modport slave  (input in, output out, output statout);
endinterface

// File: rtl/seqcheck.sv
// Moore detector for the serial pattern 1-0-1-1-0; out pulses while in the detected state.
// Build option: define SEQCHECK_OVERLAP_EN to let a detection reuse its trailing "10".
module seqcheck (
    input  logic       clk,
    input  logic       rst,
    seqcheck_if.slave  bus
);

    typedef enum logic [2:0] {
        S0 = 3'b000,
        S1 = 3'b001,
        S2 = 3'b010,
        S3 = 3'b011,
        S4 = 3'b100,
        S5 = 3'b101
    } state_t;

    state_t state;
    state_t next;
    logic   hit;

    always_comb begin
        next = S0;
        unique case (state)
            S0: next = bus.in ? S1 : S0;
            S1: next = bus.in ? S1 : S2;
            S2: next = bus.in ? S3 : S0;
            S3: next = bus.in ? S4 : S2;
            S4: next = bus.in ? S1 : S5;
`ifdef SEQCHECK_OVERLAP_EN
            S5: next = bus.in ? S3 : S0;
`else
            S5: next = bus.in ? S1 : S0;
`endif
            default: next = S0;
        endcase
    end

    // hit is registered from the next state, so it always equals (state == S5).
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S0;
            hit   <= 1'b0;
        end else begin
            state <= next;
            hit   <= (next == S5);
        end
    end

    assign bus.out     = hit;
    assign bus.statout = state;

endmodule

// File: tb/tb_seqcheck.sv
// Directed table-driven bench for seqcheck, plus hand-written reset corner sequences.
module tb_seqcheck;

    logic clk;
    logic rst;
    int unsigned checks;
    int unsigned errors;

    seqcheck_if bus ();

    seqcheck dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       in;
        logic [2:0] stat;
        logic       out;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic r, input logic i, input logic [2:0] s, input logic o);
        vec_t v;
        v.rst  = r;
        v.in   = i;
        v.stat = s;
        v.out  = o;
        vecs.push_back(v);
    endfunction

    task automatic step(input logic r, input logic i, input logic [2:0] s, input logic o,
                        input string name);
        rst    = r;
        bus.in = i;
        @(posedge clk);
        #1;
        checks++;
        if (bus.statout !== s) begin
            errors++;
            $display("FAIL %s statout got %b want %b", name, bus.statout, s);
        end
        checks++;
        if (bus.out !== o) begin
            errors++;
            $display("FAIL %s out got %b want %b", name, bus.out, o);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b0;
        bus.in = 1'b0;

        // reset with in toggling, then idle zeros
        add(1, 1, 3'b000, 0); add(1, 0, 3'b000, 0);
        add(0, 0, 3'b000, 0); add(0, 0, 3'b000, 0); add(0, 0, 3'b000, 0);
        // basic detect, then leave S5
        add(0, 1, 3'b001, 0); add(0, 0, 3'b010, 0); add(0, 1, 3'b011, 0);
        add(0, 1, 3'b100, 0); add(0, 0, 3'b101, 1); add(0, 0, 3'b000, 0);
        // overlap stream 1,0,1,1,0,1,1,0
        add(1, 0, 3'b000, 0);
        add(0, 1, 3'b001, 0); add(0, 0, 3'b010, 0); add(0, 1, 3'b011, 0);
        add(0, 1, 3'b100, 0); add(0, 0, 3'b101, 1);
`ifdef SEQCHECK_OVERLAP_EN
        add(0, 1, 3'b011, 0); add(0, 1, 3'b100, 0); add(0, 0, 3'b101, 1);
`else
        add(0, 1, 3'b001, 0); add(0, 1, 3'b001, 0); add(0, 0, 3'b010, 0);
`endif
        // near misses 1,0,1,1,1,0,0,0
        add(1, 0, 3'b000, 0);
        add(0, 1, 3'b001, 0); add(0, 0, 3'b010, 0); add(0, 1, 3'b011, 0);
        add(0, 1, 3'b100, 0); add(0, 1, 3'b001, 0); add(0, 0, 3'b010, 0);
        add(0, 0, 3'b000, 0); add(0, 0, 3'b000, 0);
        // reset mid-sequence, then full pattern
        add(1, 0, 3'b000, 0);
        add(0, 1, 3'b001, 0); add(0, 0, 3'b010, 0); add(0, 1, 3'b011, 0);
        add(0, 1, 3'b100, 0); add(1, 0, 3'b000, 0);
        add(0, 1, 3'b001, 0); add(0, 0, 3'b010, 0); add(0, 1, 3'b011, 0);
        add(0, 1, 3'b100, 0); add(0, 0, 3'b101, 1);
        // long stream (reset issued from S5)
        add(1, 0, 3'b000, 0);
        add(0, 0, 3'b000, 0); add(0, 0, 3'b000, 0); add(0, 1, 3'b001, 0);
        add(0, 0, 3'b010, 0); add(0, 1, 3'b011, 0); add(0, 0, 3'b010, 0);
        add(0, 1, 3'b011, 0); add(0, 1, 3'b100, 0); add(0, 0, 3'b101, 1);
`ifdef SEQCHECK_OVERLAP_EN
        add(0, 1, 3'b011, 0);
`else
        add(0, 1, 3'b001, 0);
`endif
        add(0, 0, 3'b010, 0); add(0, 1, 3'b011, 0); add(0, 1, 3'b100, 0);
        add(0, 1, 3'b001, 0); add(0, 0, 3'b010, 0); add(0, 0, 3'b000, 0);
        add(0, 0, 3'b000, 0); add(0, 1, 3'b001, 0); add(0, 0, 3'b010, 0);
        add(0, 1, 3'b011, 0); add(0, 0, 3'b010, 0); add(0, 1, 3'b011, 0);
        add(0, 1, 3'b100, 0); add(0, 0, 3'b101, 1); add(0, 0, 3'b000, 0);

        for (int i = 0; i < vecs.size(); i++)
            step(vecs[i].rst, vecs[i].in, vecs[i].stat, vecs[i].out, $sformatf("vec%0d", i));

        // reset taken while sitting in S5, with in=1 to prove rst wins
        step(1, 0, 3'b000, 0, "hs_rst0");
        step(0, 1, 3'b001, 0, "hs_a1");
        step(0, 0, 3'b010, 0, "hs_a2");
        step(0, 1, 3'b011, 0, "hs_a3");
        step(0, 1, 3'b100, 0, "hs_a4");
        step(0, 0, 3'b101, 1, "hs_a5");
        step(1, 1, 3'b000, 0, "hs_rst_s5");
        step(1, 1, 3'b000, 0, "hs_rst_hold");
        // pattern prefix before reset must not count toward the next detection
        step(0, 1, 3'b011 & 3'b001, 0, "hs_b1");
        step(0, 1, 3'b001, 0, "hs_b2");
        step(0, 0, 3'b010, 0, "hs_b3");
        step(0, 1, 3'b011, 0, "hs_b4");
        step(0, 1, 3'b100, 0, "hs_b5");
        step(0, 0, 3'b101, 1, "hs_b6");
        step(0, 1, 3'b001 | {1'b0, `ifdef SEQCHECK_OVERLAP_EN 2'b10 `else 2'b00 `endif}, 0, "hs_b7");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
